sdft_bin_magnitude: RTL

//   Downstream consumer of the sDFT stage: scans all frequency bins once per start request,

---
 rtl/sdft_bin_magnitude.sv | 85 ++++++++
 1 files changed

// File: rtl/sdft_bin_magnitude.sv
// sdft_bin_magnitude: scans every sDFT bin once per start and streams re^2+im^2 per bin
// ports: start/busy frame control; bin_addr -> bin_real/bin_imag registered bin read port;
//        mag_valid/mag_ready/mag_addr/mag_data result stream; frame_done pulses after the last bin
module sdft_bin_magnitude #(
  parameter int data_width = 8,
  parameter int freq_bins = 16,
  localparam int bin_w = 2 * data_width,
  localparam int bin_addr_w = $clog2(freq_bins)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic [bin_addr_w-1:0]   bin_addr,
  input  logic signed [bin_w-1:0] bin_real,
  input  logic signed [bin_w-1:0] bin_imag,
  output logic                    mag_valid,
  input  logic                    mag_ready,
  output logic [bin_addr_w-1:0]   mag_addr,
  output logic [2*bin_w-1:0]      mag_data,
  output logic                    frame_done
);
  typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, MULT, SUM, OUT} state_t;
  state_t state, next;
  logic signed [bin_w-1:0] re, im;
  logic signed [2*bin_w-1:0] re_sq, im_sq;
  logic accept, last;
  assign accept = mag_valid & mag_ready;
  assign last = bin_addr == bin_addr_w'(freq_bins - 1);
  always_comb begin
    next = state;
    next = state == IDLE    ? (start ? ADDR : IDLE) :
           state == ADDR    ? CAPTURE :
           state == CAPTURE ? MULT :
           state == MULT    ? SUM :
           state == SUM     ? OUT :
           state == OUT     ? (accept ? (last ? IDLE : ADDR) : OUT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin_addr <= '0;
      busy <= 1'b0;
      mag_valid <= 1'b0;
      mag_addr <= '0;
      mag_data <= '0;
      frame_done <= 1'b0;
      re <= '0;
      im <= '0;
      re_sq <= '0;
      im_sq <= '0;
    end else begin
      state <= next;
      frame_done <= 1'b0;
      if (state == IDLE && start) begin
        bin_addr <= '0;
        busy <= 1'b1;
      end
      if (state == CAPTURE) begin
        re <= bin_real;
        im <= bin_imag;
      end
      // size casts keep signedness, so operands are sign-extended before multiplying
      if (state == MULT) begin
        re_sq <= (2*bin_w)'(re) * (2*bin_w)'(re);
        im_sq <= (2*bin_w)'(im) * (2*bin_w)'(im);
      end
      // both squares are non-negative and their sum peaks at 2^(2*bin_w-1), so no carry is lost
      if (state == SUM) begin
        mag_data <= $unsigned(re_sq) + $unsigned(im_sq);
        mag_addr <= bin_addr;
        mag_valid <= 1'b1;
      end
      if (state == OUT && accept) begin
        mag_valid <= 1'b0;
        if (last) begin
          busy <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          bin_addr <= bin_addr + 1'b1;
        end
      end
    end
  end
endmodule
